// File: rtl/fpnew_pkg.sv
// Shared FP format, rounding and operation definitions plus width/NaN helpers.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;
  localparam int unsigned FP_FORMAT_BITS = 3;

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef logic [0:NUM_FP_FORMATS-1] fmt_logic_t;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned max_fp_width(fmt_logic_t cfg);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < NUM_FP_FORMATS; i++) begin
      if (cfg[i] && (fp_width(fp_format_e'(3'(i))) > res)) res = fp_width(fp_format_e'(3'(i)));
    end
    return res;
  endfunction

  // Canonical quiet NaN of fmt, NaN-boxed: every bit above the format width is 1.
  function automatic logic [63:0] canonical_nan_boxed(fp_format_e fmt);
    case (fmt)
      FP32:    return {32'hFFFF_FFFF, 32'h7FC0_0000};
      FP64:    return 64'h7FF8_0000_0000_0000;
      FP16:    return {48'hFFFF_FFFF_FFFF, 16'h7E00};
      FP8:     return {56'hFF_FFFF_FFFF_FFFF, 8'h7E};
      FP16ALT: return {48'hFFFF_FFFF_FFFF, 16'h7FC0};
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_issue_queue_sanitize.sv
// Combinational NaN-box check for one operand: replaces an improperly boxed
// operand of an enabled destination format with that format's canonical NaN.
module fpnew_nanbox_sanitize
  import fpnew_pkg::*;
#(
  parameter fmt_logic_t  FpFmtConfig = '1,
  parameter int unsigned WIDTH       = 64
) (
  input  logic [WIDTH-1:0] operand_i,
  input  fmt_logic_t       is_boxed_i,
  input  fp_format_e       fmt_i,
  output logic [WIDTH-1:0] operand_o
);

  logic [63:0] nan_full;

  // Select stored operand: canonical NaN when unboxed, else pass-through.
  always_comb begin
    nan_full  = canonical_nan_boxed(fmt_i);
    operand_o = operand_i;
    if (FpFmtConfig[fmt_i] && !is_boxed_i[fmt_i]) operand_o = nan_full[WIDTH-1:0];
  end

endmodule

// File: rtl/fpnew_divsqrt_issue_queue.sv
// In-order request queue in front of the div/sqrt unit. Operands are
// sanitized on enqueue; the head entry drives the unit's input handshake.
module fpnew_divsqrt_issue_queue
  import fpnew_pkg::*;
#(
  parameter fmt_logic_t  FpFmtConfig = '1,
  parameter int unsigned Depth       = 2,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic,
  localparam int unsigned WIDTH      = max_fp_width(FpFmtConfig)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [1:0][WIDTH-1:0]                operands_i,
  input  logic [0:NUM_FP_FORMATS-1][0:1]       is_boxed_i,
  input  roundmode_e                           rnd_mode_i,
  input  operation_e                           op_i,
  input  fp_format_e                           dst_fmt_i,
  input  TagType                               tag_i,
  input  AuxType                               aux_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic                                 flush_i,
  output logic [1:0][WIDTH-1:0]                operands_o,
  output roundmode_e                           rnd_mode_o,
  output operation_e                           op_o,
  output fp_format_e                           dst_fmt_o,
  output TagType                               tag_o,
  output AuxType                               aux_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o
);

  localparam int unsigned     PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned     CntW     = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LAST_PTR = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FULL_CNT = CntW'(Depth);

  typedef struct packed {
    logic [1:0][WIDTH-1:0] operands;
    roundmode_e            rnd_mode;
    operation_e            op;
    fp_format_e            dst_fmt;
    TagType                tag;
    AuxType                aux;
  } entry_t;

  entry_t            mem_q [Depth];
  entry_t            mem_d [Depth];
  entry_t            wr_entry;
  entry_t            head;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [1:0][WIDTH-1:0] san_ops;
  logic              push, pop;

  for (genvar k = 0; k < 2; k++) begin : g_san
    fmt_logic_t boxed_k;
    for (genvar f = 0; f < NUM_FP_FORMATS; f++) begin : g_fmt
      assign boxed_k[f] = is_boxed_i[f][k];
    end
    fpnew_nanbox_sanitize #(
      .FpFmtConfig (FpFmtConfig),
      .WIDTH       (WIDTH)
    ) u_sanitize (
      .operand_i  (operands_i[k]),
      .is_boxed_i (boxed_k),
      .fmt_i      (dst_fmt_i),
      .operand_o  (san_ops[k])
    );
  end

  assign in_ready_o  = (count_q != FULL_CNT) & ~flush_i;
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign head        = mem_q[rd_ptr_q];
  assign operands_o  = head.operands;
  assign rnd_mode_o  = head.rnd_mode;
  assign op_o        = head.op;
  assign dst_fmt_o   = head.dst_fmt;
  assign tag_o       = head.tag;
  assign aux_o       = head.aux;

  // Assemble the sanitized entry and write it at the tail on push.
  always_comb begin
    wr_entry = '{operands: san_ops, rnd_mode: rnd_mode_i, op: op_i,
                 dst_fmt: dst_fmt_i, tag: tag_i, aux: aux_i};
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_entry;
  end

  // Pointer/count update; flush discards everything including a same-cycle pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
module tb_fpnew_divsqrt_issue_queue;
  import fpnew_pkg::*;

  parameter int Depth = 2;
  localparam int W = 64;

  typedef struct {
    logic [7:0]  tag;
    logic [3:0]  aux;
    operation_e  op;
    roundmode_e  rnd;
    fp_format_e  fmt;
    logic [63:0] op0;
    logic [63:0] op1;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [1:0][W-1:0] opnds;
  logic [0:NUM_FP_FORMATS-1][0:1] boxed;
  roundmode_e rnd;
  operation_e op;
  fp_format_e fmt;
  logic [7:0] tag;
  logic [3:0] aux;

  logic              in_ready, out_valid, busy;
  logic [1:0][W-1:0] opnds_o;
  roundmode_e        rnd_o;
  operation_e        op_o;
  fp_format_e        fmt_o;
  logic [7:0]        tag_o;
  logic [3:0]        aux_o;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpnew_divsqrt_issue_queue #(
    .Depth   (Depth),
    .TagType (logic [7:0]),
    .AuxType (logic [3:0])
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .operands_i  (opnds),
    .is_boxed_i  (boxed),
    .rnd_mode_i  (rnd),
    .op_i        (op),
    .dst_fmt_i   (fmt),
    .tag_i       (tag),
    .aux_i       (aux),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .operands_o  (opnds_o),
    .rnd_mode_o  (rnd_o),
    .op_o        (op_o),
    .dst_fmt_o   (fmt_o),
    .tag_o       (tag_o),
    .aux_o       (aux_o),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [63:0] exp_opnd(fp_format_e f, logic bx, logic [63:0] v);
    if (bx) return v;
    case (f)
      FP32:    return 64'hFFFF_FFFF_7FC0_0000;
      FP64:    return 64'h7FF8_0000_0000_0000;
      FP16:    return 64'hFFFF_FFFF_FFFF_7E00;
      FP8:     return 64'hFFFF_FFFF_FFFF_FF7E;
      default: return 64'hFFFF_FFFF_FFFF_7FC0;
    endcase
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic step();
    exp_t e;
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (exp_q.size() != Depth) && !flush;
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("tag", 64'(tag_o), 64'(exp_q[0].tag));
        chk("aux", 64'(aux_o), 64'(exp_q[0].aux));
        chk("op", 64'(op_o), 64'(exp_q[0].op));
        chk("rnd", 64'(rnd_o), 64'(exp_q[0].rnd));
        chk("fmt", 64'(fmt_o), 64'(exp_q[0].fmt));
        chk("opnd0", opnds_o[0], exp_q[0].op0);
        chk("opnd1", opnds_o[1], exp_q[0].op1);
      end
    end
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) begin
        e.tag = tag; e.aux = aux; e.op = op; e.rnd = rnd; e.fmt = fmt;
        e.op0 = exp_opnd(fmt, boxed[fmt][0], opnds[0]);
        e.op1 = exp_opnd(fmt, boxed[fmt][1], opnds[1]);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] t, input operation_e o);
    tag = t;
    op = o;
    aux = 4'($urandom);
    rnd = roundmode_e'(3'($urandom_range(0, 4)));
    opnds[0] = {$urandom, $urandom};
    opnds[1] = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    boxed = '1; fmt = FP64;
    set_req(8'd0, DIV);
    step();
    rst = 1'b0;
    step();

    // Single request: visible at head one cycle after push, then popped.
    set_req(8'd1, DIV); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    step();

    // Fill past capacity with the sink stalled, then pop to free one slot.
    out_ready = 1'b0;
    for (int i = 1; i <= Depth + 1; i++) begin
      set_req(8'(i), SQRT); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < Depth; i++) step();

    // Streaming push+pop with pointer wrap.
    for (int i = 0; i < 10; i++) begin
      set_req(8'(i), (i % 3 == 0) ? ADD : DIV); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Sanitization: FP32 op0 unboxed, then FP16 and FP64 both unboxed.
    out_ready = 1'b0;
    set_req(8'h20, DIV); fmt = FP32;
    opnds[0] = 64'h0000_0000_3F80_0000;
    opnds[1] = 64'hFFFF_FFFF_4000_0000;
    boxed[FP32] = 2'b01; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    boxed = '0; fmt = FP16; set_req(8'h21, DIV); in_valid = 1'b1;
    step();
    fmt = FP64; set_req(8'h22, SQRT);
    step();
    in_valid = 1'b0; boxed = '1;
    step();
    step();

    // Flush while full with a concurrent push request.
    out_ready = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      set_req(8'(8'h30 + i), DIV); in_valid = 1'b1;
      step();
    end
    flush = 1'b1; out_ready = 1'b1; set_req(8'h3F, DIV);
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    set_req(8'h40, DIV); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();

    // Reset with flush while full, then confirm clean restart.
    out_ready = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      set_req(8'(8'h50 + i), DIV); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    step();
    set_req(8'h60, SQRT); in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
